// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared types and instruction field slices for the step controller.
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int INSTR_W = 10;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 3;
  localparam int RY_MSB  = 2;
  localparam int RY_LSB  = 0;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_COPY = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INV  = 4'd4,
    OP_FLIP = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_INV  = 3'd2,
    ALU_FLIP = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  // ALU function selected by an opcode; non-ALU opcodes map to PASS.
  function automatic alu_op_t alu_of(input logic [3:0] opc);
    alu_op_t res;
    case (opc)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_INV:  res = ALU_INV;
      OP_FLIP: res = ALU_FLIP;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      default: res = ALU_PASS;
    endcase
    return res;
  endfunction

endpackage : proc_pkg
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational decode of (IR, timestep) into bus controls.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import proc_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic [INSTR_W-1:0] ir,
  input  tstep_t             step,
  output logic               ext_data_en,
  output logic [NREG-1:0]    reg_rd_sel,
  output logic               g_oe,
  output alu_op_t            alu_op,
  output logic               ir_ld_en,
  output logic [NREG-1:0]    reg_wr_sel,
  output logic               a_ld_en,
  output logic               g_ld_en,
  output logic               done_en,
  output logic               last_step
);

  logic [3:0]      w_opc;
  logic [2:0]      w_rx;
  logic [2:0]      w_ry;
  logic [NREG-1:0] w_rx_oh;
  logic [NREG-1:0] w_ry_oh;
  logic            w_binary;
  logic            w_unary;

  assign w_opc = ir[OPC_MSB:OPC_LSB];
  assign w_rx  = ir[RX_MSB:RX_LSB];
  assign w_ry  = ir[RY_MSB:RY_LSB];

  assign w_binary = (w_opc == OP_ADD) || (w_opc == OP_SUB) || (w_opc == OP_AND) ||
                    (w_opc == OP_OR)  || (w_opc == OP_XOR);
  assign w_unary  = (w_opc == OP_INV) || (w_opc == OP_FLIP);

  always_comb begin
    w_rx_oh = '0;
    w_ry_oh = '0;
    for (int i = 0; i < NREG; i++) begin
      w_rx_oh[i] = (int'(w_rx) == i);
      w_ry_oh[i] = (int'(w_ry) == i);
    end
  end

  always_comb begin
    ext_data_en = 1'b0;
    reg_rd_sel  = '0;
    g_oe        = 1'b0;
    alu_op      = ALU_PASS;
    ir_ld_en    = 1'b0;
    reg_wr_sel  = '0;
    a_ld_en     = 1'b0;
    g_ld_en     = 1'b0;
    done_en     = 1'b0;
    last_step   = 1'b0;
    case (step)
      T0: ir_ld_en = 1'b1;
      T1: begin
        if (w_opc == OP_LOAD) begin
          ext_data_en = 1'b1;
          reg_wr_sel  = w_rx_oh;
          done_en     = 1'b1;
          last_step   = 1'b1;
        end else if (w_opc == OP_COPY) begin
          reg_rd_sel  = w_ry_oh;
          reg_wr_sel  = w_rx_oh;
          done_en     = 1'b1;
          last_step   = 1'b1;
        end else if (w_binary) begin
          reg_rd_sel  = w_rx_oh;
          a_ld_en     = 1'b1;
        end else if (w_unary) begin
          reg_rd_sel  = w_ry_oh;
          alu_op      = alu_of(w_opc);
          g_ld_en     = 1'b1;
        end else begin
          // Illegal opcode: retire immediately with no datapath activity.
          done_en     = 1'b1;
          last_step   = 1'b1;
        end
      end
      T2: begin
        if (w_binary) begin
          reg_rd_sel  = w_ry_oh;
          alu_op      = alu_of(w_opc);
          g_ld_en     = 1'b1;
        end else if (w_unary) begin
          g_oe        = 1'b1;
          reg_wr_sel  = w_rx_oh;
          done_en     = 1'b1;
          last_step   = 1'b1;
        end else begin
          last_step   = 1'b1;
        end
      end
      default: begin
        if (w_binary) begin
          g_oe        = 1'b1;
          reg_wr_sel  = w_rx_oh;
          done_en     = 1'b1;
        end
        last_step     = 1'b1;
      end
    endcase
  end

endmodule : instr_decoder
`default_nettype wire

// File: rtl/proc_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : proc_step_controller
// Purpose  : Holds IR and timestep, synchronises reset release, gates strobes.
// Revision : 1.0 - initial release
// ============================================================================
module proc_step_controller
  import proc_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic               clk,
  input  logic               clrb,
  input  logic               step_pulse,
  input  logic [INSTR_W-1:0] instr,
  output logic               ir_ld,
  output logic               ext_data_en,
  output logic [NREG-1:0]    reg_rd_en,
  output logic [NREG-1:0]    reg_wr_en,
  output logic               a_ld,
  output logic               g_ld,
  output logic               g_oe,
  output logic [2:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic [1:0]         step
);

  logic [1:0]         r_rst_sync;
  logic [INSTR_W-1:0] r_ir;
  tstep_t             r_step;
  tstep_t             w_step_nxt;
  logic               w_adv;

  logic               w_ext;
  logic [NREG-1:0]    w_rd_sel;
  logic               w_goe;
  alu_op_t            w_alu;
  logic               w_ir_ld_en;
  logic [NREG-1:0]    w_wr_sel;
  logic               w_a_ld_en;
  logic               w_g_ld_en;
  logic               w_done_en;
  logic               w_last;

  // Assertion is immediate; strobes stay blocked until release has crossed two flops.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_adv = r_rst_sync[1] & step_pulse;

  instr_decoder #(.NREG(NREG)) u_dec (
    .ir          (r_ir),
    .step        (r_step),
    .ext_data_en (w_ext),
    .reg_rd_sel  (w_rd_sel),
    .g_oe        (w_goe),
    .alu_op      (w_alu),
    .ir_ld_en    (w_ir_ld_en),
    .reg_wr_sel  (w_wr_sel),
    .a_ld_en     (w_a_ld_en),
    .g_ld_en     (w_g_ld_en),
    .done_en     (w_done_en),
    .last_step   (w_last)
  );

  always_comb begin
    w_step_nxt = T0;
    if (!w_last) begin
      case (r_step)
        T0:      w_step_nxt = T1;
        T1:      w_step_nxt = T2;
        T2:      w_step_nxt = T3;
        default: w_step_nxt = T0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_step <= T0;
      r_ir   <= '0;
    end else if (w_adv) begin
      r_step <= w_step_nxt;
      if (ir_ld) r_ir <= instr;
    end
  end

  assign ir_ld       = w_adv & w_ir_ld_en;
  assign reg_wr_en   = w_adv ? w_wr_sel : '0;
  assign a_ld        = w_adv & w_a_ld_en;
  assign g_ld        = w_adv & w_g_ld_en;
  assign done        = w_adv & w_done_en;
  assign ext_data_en = w_ext;
  assign reg_rd_en   = w_rd_sel;
  assign g_oe        = w_goe;
  assign alu_op      = w_alu;
  assign step        = r_step;
  assign busy        = (r_step != T0);

endmodule : proc_step_controller
`default_nettype wire

// File: doc/proc_step_controller.md
# proc_step_controller

Control unit for the 10-bit processor. It latches a 10-bit instruction and sequences the shared bus datapath (register file, ALU A/G registers, external data driver) through timesteps T0–T3. Each step advances on a single-cycle `step_pulse` strobe from the debounced clock-button edge detector. It exposes the current timestep for the seven-segment display.

## Interface
- `NREG`, default 8: number of general registers; width of the one-hot enables.
- `clk` input 1: 50 MHz system clock.
- `clrb` input 1: reset; asynchronous assert, active-low.
- `step_pulse` input 1: one-`clk` strobe; advances one timestep.
- `instr` input 10: instruction word. Fields: [9:6] opcode, [5:3] Rx, [2:0] Ry.
- `ir_ld` output 1: instruction register load strobe (also drives the internal IR).
- `ext_data_en` output 1: external data onto the bus (level).
- `reg_rd_en` output NREG: one-hot register-to-bus drive (level).
- `reg_wr_en` output NREG: one-hot register load strobe.
- `a_ld` output 1: ALU A-register load strobe.
- `g_ld` output 1: ALU G-register load strobe.
- `g_oe` output 1: G onto the bus (level).
- `alu_op` output 3: ALU function (level).
- `busy` output 1: high while the step is not T0.
- `done` output 1: strobe on the final load of an instruction.
- `step` output 2: current timestep, 0–3.

## Operation
- **Opcodes:**
  - 0000 LOAD
  - 0001 COPY
  - 0010 ADD
  - 0011 SUB
  - 0100 INV
  - 0101 FLIP
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - 1001–1111 illegal.
- **alu_op encoding:** ADD 000, SUB 001, INV 010, FLIP 011, AND 100, OR 101, XOR 110, PASS 111 (idle value).
- **Output classes:**
  - Level outputs (`ext_data_en`, `reg_rd_en`, `g_oe`, `alu_op`) are held for the whole timestep.
  - Strobes (`ir_ld`, `reg_wr_en`, `a_ld`, `g_ld`, `done`) are asserted only in the cycle where `step_pulse`=1 in that timestep.
- **Timestep state:** `step` is registered. On `step_pulse` it advances to the next T, or returns to T0 on the final step. It holds otherwise.
- **T0 (all opcodes):** `ir_ld`. The IR captures `instr`. No level outputs are asserted.
- **LOAD:** T1 `ext_data_en`, `reg_wr_en[Rx]`, `done`; then T0.
- **COPY:** T1 `reg_rd_en[Ry]`, `reg_wr_en[Rx]`, `done`; then T0.
- **Binary ops (ADD, SUB, AND, OR, XOR):**
  - T1: `reg_rd_en[Rx]`, `a_ld`.
  - T2: `reg_rd_en[Ry]`, `alu_op`=op, `g_ld`.
  - T3: `g_oe`, `reg_wr_en[Rx]`, `done`; then T0.
- **Unary ops (INV, FLIP):**
  - T1: `reg_rd_en[Ry]`, `alu_op`=op, `g_ld`.
  - T2: `g_oe`, `reg_wr_en[Rx]`, `done`; then T0.
- **Illegal opcode:** T1 asserts nothing except `done`; then T0.
- **Decode source:** decode uses the IR only, never the live `instr`. Changes on `instr` after T0 have no effect.
- **Bus invariant:** at most one bus driver (`ext_data_en`, any `reg_rd_en` bit, `g_oe`) is active in any cycle.
- **Rx = Ry:** legal. ADD R1,R1 doubles R1.

## Timing
- **Reset:** `clrb` low immediately forces:
  - `step`=0 and IR=0;
  - all strobes and enables 0;
  - `alu_op`=PASS.
  
  Reset mid-instruction abandons it, with no partial write or `done`. Release is synchronised internally with a two-flop reset synchroniser.
- **Latency:** LOAD/COPY 2 pulses, unary 3 pulses, binary 4 pulses, counted from the T0 pulse to the `done` pulse.
- **Consecutive pulses:** `step_pulse` high on consecutive cycles advances once per cycle. The source guarantees single-cycle pulses; the controller does not filter them.
- **Strobe timing:** strobes are combinational from the registered state, IR and `step_pulse`. Datapath registers capture on the same `clk` edge that advances `step`.
- **Between pulses:** with no `step_pulse`, all outputs are stable indefinitely.

## Structure
- Package `proc_pkg`:
  - `opcode_t` enum;
  - `alu_op_t` enum;
  - `tstep_t` (T0–T3);
  - field-slice constants (`OPC_MSB`/`OPC_LSB`, `RX_*`, `RY_*`).
- Sub-module `instr_decoder` (combinational): inputs IR and `step`; outputs level controls, strobe-enables (before gating with `step_pulse`), and `last_step`. The top holds the IR, the timestep register, the reset synchroniser and the strobe gating.

## Test plan
- **Reset:** hold `clrb`=0 for 3 cycles, then release → `step`=0, all outputs 0, `alu_op`=111. Then a pulse with `instr`=0000_010_000 → `ir_ld`=1 for exactly one cycle.
- **LOAD:** LOAD R2 (0000_010_000), 2 pulses → second pulse has `ext_data_en`=1, `reg_wr_en`=8'b00000100, `done`=1; `step` returns to 0.
- **ADD:** ADD R1,R3 (0010_001_011), 4 pulses →
  - T1: `reg_rd_en`=00000010, `a_ld`.
  - T2: `reg_rd_en`=00001000, `alu_op`=000, `g_ld`.
  - T3: `g_oe`, `reg_wr_en`=00000010, `done`.
  - No cycle has two bus drivers.
- **INV and illegal:** INV R0,R5 (0100_000_101) completes in 3 pulses with `alu_op`=010 at T1. Opcode 1111 → `done` at T1 with no enables.
- **Reset mid-op:** SUB R4,R6; drop `clrb` during T2 → outputs 0 asynchronously, `step`=0, and no `reg_wr_en` or `done` is ever seen.
- **Decode source:** change `instr` during T1–T3 of a COPY → the control outputs follow the latched IR.
